// File: rtl/usb_uart_cmd_parser_if.sv
// usb_uart_cmd_parser_if
// Groups the byte-FIFO handshake of the USB UART channel and the simple
// control-register bus that the command parser drives.
//   rx_req / rx_data / rx_empty : RX FIFO pop port (data valid the cycle after rx_req)
//   tx_req / tx_data / tx_full  : TX FIFO push port
//   reg_wr / reg_rd             : 1-cycle register strobes
//   reg_addr / reg_wdata        : register address and write data
//   reg_rdata                   : read data, valid 1 cycle after reg_rd
// master = command parser, slave = FIFOs plus register file.
interface usb_uart_cmd_parser_if;
  logic        rx_req;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        reg_wr;
  logic        reg_rd;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  modport master (
    output rx_req,
    input  rx_data,
    input  rx_empty,
    output tx_req,
    output tx_data,
    input  tx_full,
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  rx_req,
    output rx_data,
    output rx_empty,
    input  tx_req,
    input  tx_data,
    output tx_full,
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/usb_uart_cmd_parser.sv
// usb_uart_cmd_parser
// Host-command endpoint on the USB UART byte channel. Pops bytes from the RX
// FIFO, assembles 6-byte frames (AA CMD ADDR DH DL CHK), performs a register
// write (CMD 01) or read (CMD 02) and pushes a 6-byte response
// (55 ST ADDR RH RL RCHK) into the TX FIFO.
// Ports:
//   I_sys_clk   : system clock, rising edge
//   I_sys_rst   : asynchronous active-low reset
//   bus         : usb_uart_cmd_parser_if.master (FIFO ports + register bus)
//   O_cmd_busy  : high from header accept until the last response byte is written
//   O_frame_err : 1-cycle pulse on checksum error, unknown command or timeout
// Optional feature: define USB_CMD_TIMEOUT_EN to abandon a frame after
// P_TIMEOUT idle cycles between bytes; otherwise COLLECT waits indefinitely.
module usb_uart_cmd_parser #(
  parameter logic [15:0] P_TIMEOUT = 16'd50000
) (
  input  logic                         I_sys_clk,
  input  logic                         I_sys_rst,
  usb_uart_cmd_parser_if.master        bus,
  output logic                         O_cmd_busy,
  output logic                         O_frame_err
);

  localparam logic [7:0] SOF_CMD   = 8'hAA;
  localparam logic [7:0] SOF_RSP   = 8'h55;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCHK = 8'h01;
  localparam logic [7:0] ST_BADCMD = 8'h02;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_EXEC    = 3'd3,
    S_RDCAP   = 3'd4,
    S_SEND    = 3'd5
  } state_t;

  // XOR checksum over the four frame body bytes
  function automatic logic [7:0] xor4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction

  // Checksum failure takes precedence over command decode
  function automatic logic [7:0] frame_status(input logic [7:0] cmd, input logic [7:0] addr,
                                              input logic [7:0] dh, input logic [7:0] dl,
                                              input logic [7:0] chk);
    logic [7:0] st;
    if (xor4(cmd, addr, dh, dl) != chk) begin
      st = ST_BADCHK;
    end else if ((cmd != CMD_WR) && (cmd != CMD_RD)) begin
      st = ST_BADCMD;
    end else begin
      st = ST_OK;
    end
    return st;
  endfunction

  state_t      state_r, state_s;
  logic        rx_req_r, rx_vld_r;
  logic [2:0]  col_cnt_r, tx_cnt_r;
  logic [7:0]  cmd_r, addr_r, dh_r, dl_r, chk_r;
  logic [7:0]  st_r, rh_r, rl_r;
  logic        reg_wr_r, reg_rd_r;
  logic [7:0]  reg_addr_r;
  logic [15:0] reg_wdata_r;
  logic        busy_r, frame_err_r;

  logic        fetch_s, last_col_s, tx_fire_s, timeout_s;
  logic [7:0]  status_s, live_status_s, tx_byte_s;

  // A byte is captured in any cycle where rx_vld_r is set
  assign last_col_s    = rx_vld_r && (state_r == S_COLLECT) && (col_cnt_r == 3'd4);
  assign tx_fire_s     = (state_r == S_SEND) && !bus.tx_full;
  assign status_s      = frame_status(cmd_r, addr_r, dh_r, dl_r, chk_r);
  assign live_status_s = frame_status(cmd_r, addr_r, dh_r, dl_r, bus.rx_data);

  // Pop only while hunting/collecting, one read in flight, and never once the
  // CHK byte is arriving so the next frame's bytes stay in the FIFO.
  assign fetch_s = ((state_r == S_HUNT) || (state_r == S_COLLECT)) &&
                   !bus.rx_empty && !rx_req_r && !last_col_s;

`ifdef USB_CMD_TIMEOUT_EN
  logic [15:0] idle_cnt_r;

  // Idle cycles since the last captured byte while collecting a frame
  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) begin
      idle_cnt_r <= 16'd0;
    end else if ((state_r != S_COLLECT) || rx_vld_r) begin
      idle_cnt_r <= 16'd0;
    end else if (idle_cnt_r != P_TIMEOUT) begin
      idle_cnt_r <= idle_cnt_r + 16'd1;
    end
  end

  assign timeout_s = (state_r == S_COLLECT) && !rx_vld_r && (idle_cnt_r == P_TIMEOUT);
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^P_TIMEOUT;
  assign timeout_s        = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) begin
      state_r <= S_HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_HUNT: begin
        if (rx_vld_r && (bus.rx_data == SOF_CMD)) begin
          state_s = S_COLLECT;
        end else begin
          state_s = S_HUNT;
        end
      end
      S_COLLECT: begin
        if (last_col_s) begin
          state_s = S_CHECK;
        end else if (timeout_s) begin
          state_s = S_HUNT;
        end else begin
          state_s = S_COLLECT;
        end
      end
      S_CHECK: state_s = S_EXEC;
      S_EXEC: begin
        if (reg_rd_r) begin
          state_s = S_RDCAP;
        end else begin
          state_s = S_SEND;
        end
      end
      S_RDCAP: state_s = S_SEND;
      S_SEND: begin
        if (tx_fire_s && (tx_cnt_r == 3'd5)) begin
          state_s = S_HUNT;
        end else begin
          state_s = S_SEND;
        end
      end
      default: state_s = S_HUNT;
    endcase
  end

  // Response byte selected by the send counter
  always_comb begin
    tx_byte_s = 8'h00;
    case (tx_cnt_r)
      3'd0:    tx_byte_s = SOF_RSP;
      3'd1:    tx_byte_s = st_r;
      3'd2:    tx_byte_s = addr_r;
      3'd3:    tx_byte_s = rh_r;
      3'd4:    tx_byte_s = rl_r;
      3'd5:    tx_byte_s = xor4(st_r, addr_r, rh_r, rl_r);
      default: tx_byte_s = 8'h00;
    endcase
  end

  // Frame capture, register bus, response counters and status flags
  always_ff @(posedge I_sys_clk or negedge I_sys_rst) begin
    if (!I_sys_rst) begin
      rx_req_r    <= 1'b0;
      rx_vld_r    <= 1'b0;
      col_cnt_r   <= 3'd0;
      tx_cnt_r    <= 3'd0;
      cmd_r       <= 8'h00;
      addr_r      <= 8'h00;
      dh_r        <= 8'h00;
      dl_r        <= 8'h00;
      chk_r       <= 8'h00;
      st_r        <= 8'h00;
      rh_r        <= 8'h00;
      rl_r        <= 8'h00;
      reg_wr_r    <= 1'b0;
      reg_rd_r    <= 1'b0;
      reg_addr_r  <= 8'h00;
      reg_wdata_r <= 16'h0000;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_req_r    <= fetch_s;
      rx_vld_r    <= rx_req_r;
      busy_r      <= (state_s != S_HUNT);
      frame_err_r <= 1'b0;
      reg_wr_r    <= 1'b0;
      reg_rd_r    <= 1'b0;
      case (state_r)
        S_HUNT: begin
          col_cnt_r <= 3'd0;
          tx_cnt_r  <= 3'd0;
        end
        S_COLLECT: begin
          if (rx_vld_r) begin
            case (col_cnt_r)
              3'd0:    cmd_r  <= bus.rx_data;
              3'd1:    addr_r <= bus.rx_data;
              3'd2:    dh_r   <= bus.rx_data;
              3'd3:    dl_r   <= bus.rx_data;
              default: chk_r  <= bus.rx_data;
            endcase
            if (col_cnt_r == 3'd4) begin
              col_cnt_r   <= 3'd0;
              // Flag the error so the pulse lands in the CHECK cycle
              frame_err_r <= (live_status_s != ST_OK);
            end else begin
              col_cnt_r <= col_cnt_r + 3'd1;
            end
          end else if (timeout_s) begin
            col_cnt_r   <= 3'd0;
            frame_err_r <= 1'b1;
          end
        end
        S_CHECK: begin
          st_r <= status_s;
          rh_r <= dh_r;
          rl_r <= dl_r;
          if (status_s == ST_OK) begin
            reg_addr_r  <= addr_r;
            reg_wdata_r <= {dh_r, dl_r};
            reg_wr_r    <= (cmd_r == CMD_WR);
            reg_rd_r    <= (cmd_r == CMD_RD);
          end
        end
        S_EXEC: begin
          tx_cnt_r <= 3'd0;
        end
        S_RDCAP: begin
          rh_r <= bus.reg_rdata[15:8];
          rl_r <= bus.reg_rdata[7:0];
        end
        S_SEND: begin
          if (tx_fire_s) begin
            if (tx_cnt_r == 3'd5) begin
              tx_cnt_r <= 3'd0;
            end else begin
              tx_cnt_r <= tx_cnt_r + 3'd1;
            end
          end
        end
        default: begin
          col_cnt_r <= 3'd0;
          tx_cnt_r  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.rx_req    = rx_req_r;
  // The TX push must react to tx_full in the same cycle, so it stays combinational
  assign bus.tx_req    = tx_fire_s;
  assign bus.tx_data   = (state_r == S_SEND) ? tx_byte_s : 8'h00;
  assign bus.reg_wr    = reg_wr_r;
  assign bus.reg_rd    = reg_rd_r;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign O_cmd_busy    = busy_r;
  assign O_frame_err   = frame_err_r;

endmodule

// File: tb/tb_usb_uart_cmd_parser.sv
// tb_usb_uart_cmd_parser
// Directed bench: models the RX FIFO as a byte array, records every TX push,
// register strobe and error pulse, and compares against hand-computed frames.
module tb_usb_uart_cmd_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, ferr;

  always #5 clk = ~clk;

  usb_uart_cmd_parser_if bus();

  usb_uart_cmd_parser #(.P_TIMEOUT(16'd100)) dut (
    .I_sys_clk   (clk),
    .I_sys_rst   (rst_n),
    .bus         (bus),
    .O_cmd_busy  (busy),
    .O_frame_err (ferr)
  );

  int total = 0;
  int bad   = 0;

  // RX FIFO model: written by the stimulus, popped on rx_req
  logic [7:0] rx_mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign bus.rx_empty = (rd_ptr == wr_ptr);

  // Monitors
  int         cyc = 0;
  int         wr_cnt = 0, rd_cnt = 0, err_cnt = 0, full_req = 0, tx_cnt = 0;
  int         wr_at = 0, rd_at = 0, err_at = 0, rxreq_at = 0;
  logic [7:0] last_addr = 8'h00;
  logic [15:0] last_wdata = 16'h0000;
  logic [7:0] tx_mem [256];
  int         tx_cyc [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_req) begin
      bus.rx_data <= rx_mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
      rxreq_at    <= cyc;
    end
    if (bus.reg_wr) begin
      wr_cnt     <= wr_cnt + 1;
      wr_at      <= cyc;
      last_addr  <= bus.reg_addr;
      last_wdata <= bus.reg_wdata;
    end
    if (bus.reg_rd) begin
      rd_cnt    <= rd_cnt + 1;
      rd_at     <= cyc;
      last_addr <= bus.reg_addr;
    end
    if (ferr) begin
      err_cnt <= err_cnt + 1;
      err_at  <= cyc;
    end
    if (bus.tx_req) begin
      tx_mem[tx_cnt[7:0]] <= bus.tx_data;
      tx_cyc[tx_cnt[7:0]] <= cyc;
      tx_cnt              <= tx_cnt + 1;
      if (bus.tx_full) full_req <= full_req + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_frame(input logic [47:0] f);
    for (int i = 0; i < 6; i++) push_byte(f[47-8*i -: 8]);
  endtask

  task automatic wait_tx(input int n, input int limit);
    int k = 0;
    while ((tx_cnt < n) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check("tx_arrive", 32'(tx_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  task automatic expect_tx(input int base, input logic [47:0] e);
    for (int i = 0; i < 6; i++)
      check($sformatf("tx_byte%0d", i), 32'(tx_mem[(base + i) % 256]), 32'(e[47-8*i -: 8]));
  endtask

  // Runs one frame to completion and checks response plus strobe/error counts
  task automatic run_frame(input string tag, input logic [47:0] f, input logic [47:0] rsp,
                           input int ewr, input int erd, input int eerr);
    int base, w0, r0, e0;
    base = tx_cnt; w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    push_frame(f);
    wait_tx(base + 6, 400);
    wait_idle(50);
    expect_tx(base, rsp);
    check({tag, "_wr"},  32'(wr_cnt - w0),  32'(ewr));
    check({tag, "_rd"},  32'(rd_cnt - r0),  32'(erd));
    check({tag, "_err"}, 32'(err_cnt - e0), 32'(eerr));
  endtask

  initial begin
    int base, e0, k;
    bus.tx_full   = 1'b0;
    bus.reg_rdata = 16'hBEEF;
    bus.rx_data   = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rx_req",   32'(bus.rx_req),    32'd0);
    check("rst_tx_req",   32'(bus.tx_req),    32'd0);
    check("rst_tx_data",  32'(bus.tx_data),   32'd0);
    check("rst_reg_wr",   32'(bus.reg_wr),    32'd0);
    check("rst_reg_rd",   32'(bus.reg_rd),    32'd0);
    check("rst_reg_addr", 32'(bus.reg_addr),  32'd0);
    check("rst_wdata",    32'(bus.reg_wdata), 32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_err",      32'(ferr),          32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write
    base = tx_cnt;
    run_frame("wr", 48'hAA01_1012_3437, 48'h5500_1012_3436, 1, 0, 0);
    check("wr_addr",  32'(last_addr),     32'h10);
    check("wr_data",  32'(last_wdata),    32'h1234);
    check("wr_hold",  32'(bus.reg_addr),  32'h10);
    check("wr_lat",   32'(tx_cyc[base] - wr_at), 32'd1);

    // Read
    base = tx_cnt;
    run_frame("rd", 48'hAA02_2000_0022, 48'h5500_20BE_EF71, 0, 1, 0);
    check("rd_addr",  32'(last_addr), 32'h20);
    check("rd_lat",   32'(tx_cyc[base] - rd_at), 32'd2);

    // Bad checksum
    run_frame("chk", 48'hAA01_1012_3400, 48'h5501_1012_3437, 0, 0, 1);

    // Leading garbage then unknown command
    push_byte(8'h00);
    push_byte(8'hFF);
    run_frame("cmd", 48'hAA07_1000_0017, 48'h5502_1000_0012, 0, 0, 1);

    // AA inside the body is payload
    run_frame("aa", 48'hAA01_AA12_348D, 48'h5500_AA12_348C, 1, 0, 0);
    check("aa_addr", 32'(last_addr), 32'hAA);

    // TX backpressure
    base = tx_cnt;
    e0 = full_req;
    bus.tx_full = 1'b1;
    push_frame(48'hAA01_3056_781F);
    repeat (30) @(negedge clk);
    check("bp_none", 32'(tx_cnt - base), 32'd0);
    bus.tx_full = 1'b0;
    k = 0;
    while ((tx_cnt < base + 2) && (k < 50)) begin
      @(negedge clk);
      k++;
    end
    bus.tx_full = 1'b1;
    repeat (20) @(negedge clk);
    check("bp_two", 32'(tx_cnt - base), 32'd2);
    check("bp_busy", 32'(busy), 32'd1);
    bus.tx_full = 1'b0;
    wait_tx(base + 6, 100);
    expect_tx(base, 48'h5500_3056_781E);
    check("bp_fullreq", 32'(full_req - e0), 32'd0);
    wait_idle(50);

`ifdef USB_CMD_TIMEOUT_EN
    // Timeout abandons the frame without a response
    base = tx_cnt;
    e0 = err_cnt;
    push_byte(8'hAA);
    push_byte(8'h01);
    repeat (150) @(negedge clk);
    check("to_err",  32'(err_cnt - e0), 32'd1);
    check("to_lat",  32'((err_at - rxreq_at >= 100) && (err_at - rxreq_at <= 105)), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_tx",   32'(tx_cnt - base), 32'd0);
    run_frame("to_next", 48'hAA01_1012_3437, 48'h5500_1012_3436, 1, 0, 0);
`else
    // Without timeout a long gap just stalls the frame
    base = tx_cnt;
    e0 = err_cnt;
    push_byte(8'hAA);
    push_byte(8'h01);
    push_byte(8'h10);
    repeat (150) @(negedge clk);
    check("gap_err",  32'(err_cnt - e0), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_tx",   32'(tx_cnt - base), 32'd0);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h37);
    wait_tx(base + 6, 200);
    expect_tx(base, 48'h5500_1012_3436);
    wait_idle(50);
`endif

    // Reset in the middle of a response abandons it
    base = tx_cnt;
    bus.tx_full = 1'b1;
    push_frame(48'hAA01_1012_3437);
    repeat (30) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(bus.reg_addr), 32'd0);
    rst_n = 1'b1;
    bus.tx_full = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_tx",   32'(tx_cnt - base), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
